// File: rtl/qr_pkg.sv
// qr_pkg: owner state encodings and read-tag layout shared by the BRAM read arbiter.
package qr_pkg;
  typedef enum logic [1:0] {
    OWN_DISP   = 2'd0,
    OWN_SWITCH = 2'd1,
    OWN_PROC   = 2'd2
  } owner_e;
  localparam int TAG_W    = 2;
  localparam int TAG_DISP = 0;
  localparam int TAG_PROC = 1;
  localparam int CNT_W    = 3;
endpackage

// File: rtl/read_tag_pipe.sv
// read_tag_pipe: DEPTH-stage shift pipeline carrying requester tags alongside BRAM latency.
module read_tag_pipe #(
  parameter int DEPTH = 2,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);
  logic [W-1:0] pipe_q [DEPTH];
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) pipe_q <= '{default: '0};
    else begin
      pipe_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  assign tag_o = pipe_q[DEPTH-1];
endmodule

// File: rtl/bram_read_arbiter.sv
// bram_read_arbiter: shares one BRAM read port between display and processing owners.
// Define BRAM_READ_ARBITER_BORROW_EN to let processing borrow idle display cycles.
module bram_read_arbiter
  import qr_pkg::*;
#(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 1,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  mode_in,
  input  logic                  disp_req_in,
  input  logic [ADDR_WIDTH-1:0] disp_addr_in,
  output logic                  disp_valid_out,
  output logic [DATA_WIDTH-1:0] disp_data_out,
  input  logic                  proc_req_in,
  input  logic [ADDR_WIDTH-1:0] proc_addr_in,
  output logic                  proc_ready_out,
  output logic                  proc_valid_out,
  output logic [DATA_WIDTH-1:0] proc_data_out,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  output logic                  bram_en_out,
  input  logic [DATA_WIDTH-1:0] bram_data_in,
  output logic [1:0]            owner_out,
  output logic                  busy_out
);
`ifdef BRAM_READ_ARBITER_BORROW_EN
  localparam logic BORROW = 1'b1;
`else
  localparam logic BORROW = 1'b0;
`endif
  owner_e           state_q, state_d;
  logic             tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             disp_issue, proc_issue;
  logic [TAG_W-1:0] tag_in, tag_out;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      state_q <= OWN_DISP;
      tgt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  // A mode change while switching restarts the full drain window toward the new target
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if ((state_q == OWN_DISP && mode_in) || (state_q == OWN_PROC && !mode_in)) begin
      state_d = OWN_SWITCH;
      tgt_d   = mode_in;
      cnt_d   = CNT_W'(READ_LATENCY);
    end else if (state_q == OWN_SWITCH) begin
      if (mode_in != tgt_q) begin
        tgt_d = mode_in;
        cnt_d = CNT_W'(READ_LATENCY);
      end else if (cnt_q == CNT_W'(1)) begin
        state_d = tgt_q ? OWN_PROC : OWN_DISP;
        cnt_d   = '0;
      end else cnt_d = cnt_q - CNT_W'(1);
    end
  end
  assign proc_ready_out = state_q == OWN_PROC || (BORROW && state_q == OWN_DISP && !disp_req_in);
  assign disp_issue     = state_q == OWN_DISP && disp_req_in;
  assign proc_issue     = proc_ready_out && proc_req_in;
  assign bram_en_out    = disp_issue || proc_issue;
  assign bram_addr_out  = disp_issue ? disp_addr_in : proc_issue ? proc_addr_in : '0;
  assign owner_out      = state_q;
  assign busy_out       = state_q == OWN_SWITCH;
  always_comb begin
    tag_in           = '0;
    tag_in[TAG_DISP] = disp_issue;
    tag_in[TAG_PROC] = proc_issue;
  end
  read_tag_pipe #(.DEPTH(READ_LATENCY), .W(TAG_W)) u_tags (
    .clk_i(clk_in),
    .rst_i(rst_in),
    .tag_i(tag_in),
    .tag_o(tag_out)
  );
  assign disp_valid_out = tag_out[TAG_DISP];
  assign proc_valid_out = tag_out[TAG_PROC];
  assign disp_data_out  = disp_valid_out ? bram_data_in : '0;
  assign proc_data_out  = proc_valid_out ? bram_data_in : '0;
endmodule

// File: doc/bram_read_arbiter.md
BRAM_READ_ARBITER -- requirements
Module: bram_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 20, read address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 1, BRAM read data width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, BRAM addr-to-data cycles (range 1..4).
REQ-004 SHALL have port clk_in  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port mode_in  input  1  requested owner: 0 display, 1 processing.
REQ-007 SHALL have port disp_req_in  input  1  display read request, no backpressure.
REQ-008 SHALL have port disp_addr_in  input  ADDR_WIDTH  display read address.
REQ-009 SHALL have port disp_valid_out  output  1  display data valid.
REQ-010 SHALL have port disp_data_out  output  DATA_WIDTH  display read data.
REQ-011 SHALL have port proc_req_in  input  1  processing request (valid).
REQ-012 SHALL have port proc_addr_in  input  ADDR_WIDTH  processing read address.
REQ-013 SHALL have port proc_ready_out  output  1  processing request accepted when high with proc_req_in.
REQ-014 SHALL have port proc_valid_out  output  1  processing data valid.
REQ-015 SHALL have port proc_data_out  output  DATA_WIDTH  processing read data.
REQ-016 SHALL have ports bram_addr_out  output  ADDR_WIDTH, bram_en_out  output  1: shared BRAM read port.
REQ-017 SHALL have port bram_data_in  input  DATA_WIDTH  BRAM read data.
REQ-018 SHALL have port owner_out  output  2  current state encoding; busy_out  output  1  high in SWITCH.

Function
REQ-019 SHALL implement states DISP, SWITCH, PROC; owner_out = 0/1/2 respectively.
REQ-020 DISP: disp_req_in issues read (bram_en_out=1, bram_addr_out=disp_addr_in) same cycle, combinationally.
REQ-021 PROC: proc_ready_out=1; proc_req_in issues read with proc_addr_in same cycle; disp_req_in ignored, no disp_valid_out generated.
REQ-022 SWITCH: no reads issued; proc_ready_out=0; lasts exactly READ_LATENCY cycles via down-counter.
REQ-023 DISP->SWITCH when mode_in=1; PROC->SWITCH when mode_in=0; SWITCH->target owner when counter expires.
REQ-024 mode_in change during SWITCH: target updated, counter reloaded to READ_LATENCY.
REQ-025 proc_ready_out SHALL NOT depend combinationally on proc_req_in.
REQ-026 Each issued read SHALL push a requester tag into a READ_LATENCY-deep shift pipeline; matching *_valid_out asserts exactly READ_LATENCY cycles after issue for one cycle.
REQ-027 *_data_out SHALL equal bram_data_in whenever respective valid asserted; otherwise 0.
REQ-028 In-flight reads SHALL complete to their issuing requester regardless of state changes.
REQ-029 bram_en_out=0 and bram_addr_out=0 on cycles with no issue.
REQ-030 Back-to-back issues every cycle SHALL be supported with full throughput.

Reset
REQ-031 rst_in SHALL force state DISP, counter 0, tag pipeline cleared, all valid outputs 0, busy_out 0.
REQ-032 Reset mid-read SHALL discard in-flight reads; no valid pulses after reset release for them.

Configuration
REQ-033 With BRAM_READ_ARBITER_BORROW_EN defined, in DISP proc_ready_out = ~disp_req_in, letting processing use idle display cycles.
REQ-034 Without BRAM_READ_ARBITER_BORROW_EN, proc_ready_out=0 in DISP and SWITCH.

Structure
REQ-035 Owner state enum and owner_out encodings SHALL live in shared package qr_pkg.
REQ-036 Tag pipeline SHALL be sub-module read_tag_pipe (parameter DEPTH=READ_LATENCY).

Verification
REQ-037 Reset, mode_in=0, disp_req_in=1 addr 5..9 consecutive -> bram_addr 5..9 same cycles, disp_valid_out 5 cycles starting 2 cycles later.
REQ-038 mode_in 0->1 with display read in flight -> that read's disp_valid fires, busy_out high 2 cycles, then owner_out=2, proc_ready_out=1.
REQ-039 PROC, proc_req_in=1 addr 100, bram_data_in=1 two cycles later -> proc_valid_out=1, proc_data_out=1; disp_req_in ignored.
REQ-040 BORROW_EN, DISP, disp_req_in alternating 1/0, proc_req_in=1 -> proc reads issued only on disp-idle cycles, tags correct.
REQ-041 mode_in toggled 1->0 one cycle into SWITCH -> counter reloads, SWITCH lasts 3 cycles total, lands DISP.
REQ-042 rst_in asserted one cycle after issue -> no valid output afterwards, state DISP.
